mmio_dump_sequencer: RTL

- Synthesizable initiator that emits the tiny-SoC MMIO signalling protocol from inside the design.
- On a start trigger it walks the integer register file through a 1-cycle-latency read port and issues one MMIO write per register to the register-dump address, carrying value and taint (_t0).
- After the last register it optionally issues the stop-signal write.
- When idle it forwards single-beat stream samples as writes to the register-stream address.
- Sits between the core's debug/regfile read port and the MMIO request port of top_tiny_soc.

---
 rtl/mmio_dump_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mmio_dump_sequencer.sv
// mmio_dump_sequencer
// MMIO write initiator for the tiny-SoC signalling protocol. On start it walks
// the integer register file through a 1-cycle-latency read port and emits one
// write per register (value + taint) to the register-dump address. An optional
// stop-signal write follows the last register. While idle, single-beat stream
// samples are forwarded as writes to the register-stream address.
module mmio_dump_sequencer #(
    parameter int unsigned NUM_REGS        = 31,
    parameter int unsigned FIRST_REG       = 1,
    parameter logic [31:0] ADDR_REG_DUMP   = 32'h6000_0010,
    parameter logic [31:0] ADDR_REG_STREAM = 32'h6000_0020,
    parameter logic [31:0] ADDR_STOP_SIG   = 32'h6000_0000,
    parameter int unsigned STOP_AFTER_DUMP = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        rf_re_o,
    output logic [4:0]  rf_raddr_o,
    input  logic [63:0] rf_rdata_i,
    input  logic [63:0] rf_rdata_t0_i,
    input  logic        stream_valid_i,
    output logic        stream_ready_o,
    input  logic [63:0] stream_data_i,
    input  logic [63:0] stream_data_t0_i,
    output logic        mmio_req_o,
    input  logic        mmio_gnt_i,
    output logic        mmio_we_o,
    output logic [31:0] mmio_addr_o,
    output logic [7:0]  mmio_strb_o,
    output logic [63:0] mmio_wdata_o,
    output logic [63:0] mmio_wdata_t0_o
);

    // The register index is 5 bits wide, so the dumped range must fit in 0..31.
    if (FIRST_REG + NUM_REGS > 32) begin : g_bad_reg_range
        $error("mmio_dump_sequencer: FIRST_REG + NUM_REGS must not exceed 32");
    end

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'((NUM_REGS == 0) ? FIRST_REG
                                                         : FIRST_REG + NUM_REGS - 1);
    localparam bit HAS_REGS = (NUM_REGS != 0);
    localparam bit HAS_STOP = (STOP_AFTER_DUMP != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_REQ,
        ST_STOP,
        ST_SREQ,
        ST_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] wdata_t0_q, wdata_t0_d;
    logic [7:0]  strb_q, strb_d;
    logic        done_q, done_d;

    logic        xfer;
    logic        rf_re;
    logic        stream_ready;

    // A transfer completes at the edge where a held request meets a grant.
    assign xfer = req_q & mmio_gnt_i;

    // Next-state, request loading and combinational handshakes.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        req_d        = req_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wdata_t0_d   = wdata_t0_q;
        strb_d       = strb_q;
        done_d       = 1'b0;
        rf_re        = 1'b0;
        stream_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    idx_d = FIRST_IDX;
                    if (HAS_REGS) begin
                        state_d = ST_RD;
                    end else if (HAS_STOP) begin
                        req_d      = 1'b1;
                        addr_d     = ADDR_STOP_SIG;
                        wdata_d    = '0;
                        wdata_t0_d = '0;
                        strb_d     = '1;
                        state_d    = ST_STOP;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (stream_valid_i && !rst_i) begin
                    stream_ready = 1'b1;
                    req_d        = 1'b1;
                    addr_d       = ADDR_REG_STREAM;
                    wdata_d      = stream_data_i;
                    wdata_t0_d   = stream_data_t0_i;
                    strb_d       = '1;
                    state_d      = ST_SREQ;
                end
            end

            ST_RD: begin
                rf_re   = 1'b1;
                state_d = ST_CAP;
            end

            ST_CAP: begin
                req_d      = 1'b1;
                addr_d     = ADDR_REG_DUMP;
                wdata_d    = rf_rdata_i;
                wdata_t0_d = rf_rdata_t0_i;
                strb_d     = '1;
                state_d    = ST_REQ;
            end

            ST_REQ: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        if (HAS_STOP) begin
                            // Stop write is loaded on the same edge so it
                            // follows the last dump write back to back.
                            req_d      = 1'b1;
                            addr_d     = ADDR_STOP_SIG;
                            wdata_d    = '0;
                            wdata_t0_d = '0;
                            strb_d     = '1;
                            state_d    = ST_STOP;
                        end else begin
                            req_d   = 1'b0;
                            state_d = ST_DONE;
                        end
                    end else begin
                        req_d   = 1'b0;
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_RD;
                    end
                end
            end

            ST_STOP: begin
                if (xfer) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end

            ST_SREQ: begin
                if (xfer) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, index and registered MMIO outputs; reset drops any request in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= FIRST_IDX;
            req_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wdata_t0_q <= '0;
            strb_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wdata_t0_q <= wdata_t0_d;
            strb_q     <= strb_d;
            done_q     <= done_d;
        end
    end

    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = done_q;
    assign rf_re_o         = rf_re;
    assign rf_raddr_o      = rf_re ? idx_q : '0;
    assign stream_ready_o  = stream_ready;
    assign mmio_req_o      = req_q;
    assign mmio_we_o       = req_q;
    assign mmio_addr_o     = addr_q;
    assign mmio_strb_o     = strb_q;
    assign mmio_wdata_o    = wdata_q;
    assign mmio_wdata_t0_o = wdata_t0_q;

endmodule
